// File: rtl/logic_op_arbiter_if.sv
// Connection bundle between the arbiter and one shared Logic_op unit.
// The arbiter drives the master side; the Logic_op unit sits on the slave side.
interface logic_op_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
);
  logic [WIDTH-1:0] lu_A;
  logic [WIDTH-1:0] lu_B;
  logic [OPW-1:0]   lu_op;
  logic             lu_start;
  logic [WIDTH-1:0] lu_C;
  logic             lu_finish;

  modport master (
    output lu_A,
    output lu_B,
    output lu_op,
    output lu_start,
    input  lu_C,
    input  lu_finish
  );

  modport slave (
    input  lu_A,
    input  lu_B,
    input  lu_op,
    input  lu_start,
    output lu_C,
    output lu_finish
  );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one Logic_op unit between two requesters.
// Define LOGIC_ARB_TIMEOUT_EN to add the WAIT watchdog and the err output.
module logic_op_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
`ifdef LOGIC_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 16
`endif
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [OPW-1:0]     op0,
  output logic               done0,
  output logic [WIDTH-1:0]   res0,

  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  input  logic [OPW-1:0]     op1,
  output logic               done1,
  output logic [WIDTH-1:0]   res1,

  logic_op_arbiter_if.master lu,

  output logic               busy,
  output logic               owner
`ifdef LOGIC_ARB_TIMEOUT_EN
  ,
  output logic               err
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] lu_a_q,  lu_a_d;
  logic [WIDTH-1:0] lu_b_q,  lu_b_d;
  logic [OPW-1:0]   lu_op_q, lu_op_d;
  logic             owner_q, owner_d;
  logic             rr_q,    rr_d;
  logic [WIDTH-1:0] res0_q,  res0_d;
  logic [WIDTH-1:0] res1_q,  res1_d;

  logic             any_req;
  logic             grant;
  logic             cap_en;
  logic [WIDTH-1:0] cap_val;
  logic             lu_start;

`ifdef LOGIC_ARB_TIMEOUT_EN
  localparam int WDW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;

  logic [WDW-1:0] wd_q, wd_d;
  logic           to_q, to_d;
`endif

  // Winner selection: a lone requester always wins; on contention the
  // round-robin pointer decides.
  always_comb begin
    any_req = req0 | req1;
    grant   = (req0 & req1) ? rr_q : req1;
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    state_d = state_q;
    lu_a_d  = lu_a_q;
    lu_b_d  = lu_b_q;
    lu_op_d = lu_op_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    cap_en  = 1'b0;
    cap_val = lu.lu_C;
`ifdef LOGIC_ARB_TIMEOUT_EN
    wd_d    = wd_q;
    to_d    = to_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // A finish still high from an earlier op would be mistaken for this
        // op's completion, so hold off granting until it drops.
        if (any_req && !lu.lu_finish) begin
          state_d = ST_ISSUE;
          owner_d = grant;
          lu_a_d  = grant ? a1  : a0;
          lu_b_d  = grant ? b1  : b0;
          lu_op_d = grant ? op1 : op0;
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef LOGIC_ARB_TIMEOUT_EN
        wd_d    = '0;
        to_d    = 1'b0;
`endif
      end

      ST_WAIT: begin
        if (lu.lu_finish) begin
          cap_en  = 1'b1;
          cap_val = lu.lu_C;
          state_d = ST_RESP;
        end
`ifdef LOGIC_ARB_TIMEOUT_EN
        else if (wd_q == WDW'(TIMEOUT - 1)) begin
          cap_en  = 1'b1;
          cap_val = '1;
          to_d    = 1'b1;
          state_d = ST_RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
`endif
      end

      ST_RESP: begin
        rr_d    = ~owner_q;
        state_d = ST_IDLE;
`ifdef LOGIC_ARB_TIMEOUT_EN
        to_d    = 1'b0;
`endif
      end

      default: state_d = ST_IDLE;
    endcase

    // Only the owner's result register moves; the other one holds.
    if (cap_en) begin
      if (owner_q) res1_d = cap_val;
      else         res0_d = cap_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the result registers are architecturally visible outputs with a
      // defined reset value, so they are reset like the control state.
      state_q <= ST_IDLE;
      lu_a_q  <= '0;
      lu_b_q  <= '0;
      lu_op_q <= '0;
      owner_q <= 1'b0;
      rr_q    <= 1'b0;
      res0_q  <= '0;
      res1_q  <= '0;
`ifdef LOGIC_ARB_TIMEOUT_EN
      wd_q    <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      lu_a_q  <= lu_a_d;
      lu_b_q  <= lu_b_d;
      lu_op_q <= lu_op_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
`ifdef LOGIC_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
      to_q    <= to_d;
`endif
    end
  end

  assign lu_start    = (state_q == ST_ISSUE);
  assign lu.lu_start = lu_start;
  assign lu.lu_A     = lu_a_q;
  assign lu.lu_B     = lu_b_q;
  assign lu.lu_op    = lu_op_q;

  assign done0 = (state_q == ST_RESP) & ~owner_q;
  assign done1 = (state_q == ST_RESP) &  owner_q;
  assign res0  = res0_q;
  assign res1  = res1_q;
  assign busy  = (state_q != ST_IDLE);
  assign owner = owner_q;

`ifdef LOGIC_ARB_TIMEOUT_EN
  assign err = (state_q == ST_RESP) & to_q;
`endif

  a_done_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(done0 && done1));

  a_start_single: assert property (@(posedge clk) disable iff (rst)
    lu_start |=> !lu_start);

  a_operands_stable: assert property (@(posedge clk) disable iff (rst)
    (state_q == ST_WAIT) |-> $stable({lu_a_q, lu_b_q, lu_op_q}));

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter: vector table, directed corner
// sequences and randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_logic_op_arbiter;
  localparam int WIDTH = 32;
  localparam int OPW   = 3;

  localparam logic [OPW-1:0] OP_AND   = 3'd0;
  localparam logic [OPW-1:0] OP_OR    = 3'd1;
  localparam logic [OPW-1:0] OP_XOR   = 3'd2;
  localparam logic [OPW-1:0] OP_NAND  = 3'd3;
  localparam logic [OPW-1:0] OP_NOR   = 3'd4;
  localparam logic [OPW-1:0] OP_XNOR  = 3'd5;
  localparam logic [OPW-1:0] OP_NOTA  = 3'd6;
  localparam logic [OPW-1:0] OP_PASSB = 3'd7;

  typedef struct {
    logic             r0;
    logic             r1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [OPW-1:0]   op0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic [OPW-1:0]   op1;
    int               lat;
    logic             exp_owner;
    logic [WIDTH-1:0] exp_res;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [OPW-1:0]   op0, op1;
  logic             done0, done1;
  logic [WIDTH-1:0] res0, res1;
  logic             busy, owner;
`ifdef LOGIC_ARB_TIMEOUT_EN
  logic             err;
`endif

  logic_op_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) lu ();

  logic             m_finish     = 1'b0;
  logic             stale_finish = 1'b0;
  logic [WIDTH-1:0] m_c          = '0;
  logic [WIDTH-1:0] unit_c;
  int               unit_lat     = 1;
  bit               unit_en      = 1'b1;

  assign lu.lu_finish = m_finish | stale_finish;
  assign lu.lu_C      = m_c;

  int               vectors     = 0;
  int               miscompares = 0;
  logic             ptr_model;
  logic [WIDTH-1:0] res_hold [2];

  logic_op_arbiter #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .a0    (a0),
    .b0    (b0),
    .op0   (op0),
    .done0 (done0),
    .res0  (res0),
    .req1  (req1),
    .a1    (a1),
    .b1    (b1),
    .op1   (op1),
    .done1 (done1),
    .res1  (res1),
    .lu    (lu.master),
    .busy  (busy),
    .owner (owner)
`ifdef LOGIC_ARB_TIMEOUT_EN
    ,
    .err   (err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] lu_func(input logic [OPW-1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      OP_XNOR: return ~(a ^ b);
      OP_NOTA: return ~a;
      default: return b;
    endcase
  endfunction

  // Behavioural Logic_op unit: finish pulses for one cycle, unit_lat cycles
  // after the cycle in which start was high.
  always begin
    @(negedge clk);
    if (unit_en && lu.lu_start === 1'b1) begin
      unit_c = lu_func(lu.lu_op, lu.lu_A, lu.lu_B);
      repeat (unit_lat) @(negedge clk);
      m_c      = unit_c;
      m_finish = 1'b1;
      @(negedge clk);
      m_finish = 1'b0;
      m_c      = $urandom();
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_done", {30'd0, done1, done0}, 0);
    check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);
    check("rst_start", lu.lu_start, 0);
    check("rst_res0", res0, 0);
    check("rst_res1", res1, 0);
    check("rst_lu_A", lu.lu_A, 0);
    check("rst_lu_B", lu.lu_B, 0);
    check("rst_lu_op", lu.lu_op, 0);
`ifdef LOGIC_ARB_TIMEOUT_EN
    check("rst_err", err, 0);
`endif
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst         = 1'b0;
    res_hold[0] = '0;
    res_hold[1] = '0;
    ptr_model   = 1'b0;
  endtask

  // One transaction from an IDLE negedge to the IDLE negedge after RESP.
  // drop_mode: 0 keep reqs, 1 drop winner's req at done, 2 drop both.
  task automatic run_txn(input vec_t v, input int drop_mode, output int start_wait);
    int               n;
    logic [WIDTH-1:0] ea, eb;
    logic [OPW-1:0]   eop;
    req0 = v.r0;  a0 = v.a0;  b0 = v.b0;  op0 = v.op0;
    req1 = v.r1;  a1 = v.a1;  b1 = v.b1;  op1 = v.op1;
    unit_lat = v.lat;
    ea  = v.exp_owner ? v.a1  : v.a0;
    eb  = v.exp_owner ? v.b1  : v.b0;
    eop = v.exp_owner ? v.op1 : v.op0;

    n = 0;
    while (lu.lu_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    start_wait = n;
    check("start_seen", lu.lu_start, 1);
    check("lu_A", lu.lu_A, ea);
    check("lu_B", lu.lu_B, eb);
    check("lu_op", lu.lu_op, eop);
    check("owner", owner, v.exp_owner);
    check("busy", busy, 1);

    n = 0;
    while (done0 !== 1'b1 && done1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("start_to_done", n, v.lat + 1);
    check("done_vec", {30'd0, done1, done0}, v.exp_owner ? 2 : 1);
    check("res_owner", v.exp_owner ? res1 : res0, v.exp_res);
    check("res_other", v.exp_owner ? res0 : res1, res_hold[!v.exp_owner]);
`ifdef LOGIC_ARB_TIMEOUT_EN
    check("err_clear", err, 0);
`endif
    res_hold[v.exp_owner] = v.exp_res;

    if (drop_mode == 2) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end else if (drop_mode == 1) begin
      if (v.exp_owner) req1 = 1'b0;
      else             req0 = 1'b0;
    end

    @(negedge clk);
    check("done_width", {30'd0, done1, done0}, 0);
    check("idle_gap", busy, 0);
  endtask

  initial begin
    vec_t tbl [8];
    vec_t v;
    int   sw;
    int   n;
    bit   pend [2];
    logic [WIDTH-1:0] ra [2];
    logic [WIDTH-1:0] rb [2];
    logic [OPW-1:0]   rop [2];
    logic win;

    tbl[0] = '{1'b1, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, OP_AND,  32'h0,         32'h0,         OP_AND,   1, 1'b0, 32'h00F0_00F0};
    tbl[1] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0,         OP_AND,  32'h1234_5678, 32'h8765_4321, OP_OR,    2, 1'b1, 32'h9775_5779};
    tbl[2] = '{1'b1, 1'b1, 32'hFFFF_0000, 32'h00FF_FF00, OP_XOR,  32'h1111_1111, 32'h2222_2222, OP_AND,   3, 1'b0, 32'hFF00_FF00};
    tbl[3] = '{1'b0, 1'b1, 32'h0,         32'h0,         OP_AND,  32'h0,         32'h0,         OP_NOR,   2, 1'b1, 32'hFFFF_FFFF};
    tbl[4] = '{1'b0, 1'b1, 32'h0,         32'h0,         OP_AND,  32'hA5A5_A5A5, 32'hA5A5_A5A4, OP_XNOR,  1, 1'b1, 32'hFFFF_FFFE};
    tbl[5] = '{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_FFFF, OP_NAND, 32'h1,         32'h1,         OP_OR,    5, 1'b0, 32'hFFFF_0000};
    tbl[6] = '{1'b1, 1'b1, 32'h1,         32'h1,         OP_AND,  32'h0,         32'hDEAD_BEEF, OP_PASSB, 1, 1'b1, 32'hDEAD_BEEF};
    tbl[7] = '{1'b1, 1'b0, 32'h0F0F_0F0F, 32'h1234_5678, OP_NOTA, 32'h0,         32'h0,         OP_AND,   4, 1'b0, 32'hF0F0_F0F0};

    // Reset held two cycles with req0 already up, then the single AND op.
    rst  = 1'b1;
    req0 = 1'b1;  a0 = 32'hF0F0_F0F0;  b0 = 32'h0FF0_0FF0;  op0 = OP_AND;
    req1 = 1'b0;  a1 = '0;             b1 = '0;             op1 = OP_AND;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst         = 1'b0;
    res_hold[0] = '0;
    res_hold[1] = '0;
    run_txn(tbl[0], 2, sw);
    check("start_after_reset", sw, 1);

    // Contention: both requests held continuously, grants alternate 0,1,0,1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      v.r0 = 1'b1;  v.a0 = 32'h1000_0000 + WIDTH'(k);  v.b0 = '1;             v.op0 = OP_AND;
      v.r1 = 1'b1;  v.a1 = WIDTH'(k) << 4;            v.b1 = 32'h0F0F_0000;   v.op1 = OP_OR;
      v.lat       = 1 + (k % 2);
      v.exp_owner = (k % 2 == 1);
      v.exp_res   = (k % 2 == 1) ? (32'h0F0F_0000 | (WIDTH'(k) << 4))
                                 : (32'h1000_0000 + WIDTH'(k));
      run_txn(v, 0, sw);
    end
    req0 = 1'b0;
    req1 = 1'b0;

    // Vector table, starting from the reset pointer.
    do_reset();
    for (int i = 0; i < 8; i++) run_txn(tbl[i], 2, sw);

    // Stale finish in IDLE blocks the grant until it drops.
    v = '{1'b0, 1'b1, 32'h0, 32'h0, OP_AND, 32'hFFFF_1234, 32'h0000_FFFF, OP_AND, 2, 1'b1, 32'h0000_1234};
    stale_finish = 1'b1;
    req1 = 1'b1;  a1 = v.a1;  b1 = v.b1;  op1 = v.op1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("stale_no_start", lu.lu_start, 0);
      check("stale_no_busy", busy, 0);
    end
    stale_finish = 1'b0;
    run_txn(v, 2, sw);
    check("start_after_stale", sw, 1);

    // Operand change and req drop during WAIT.
    req0 = 1'b1;  a0 = 32'h1357_9BDF;  b0 = 32'hFFFF_0000;  op0 = OP_OR;
    unit_lat = 4;
    n = 0;
    while (lu.lu_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stab_start", lu.lu_start, 1);
    @(negedge clk);
    a0   = '0;
    req0 = 1'b0;
    @(negedge clk);
    check("stab_lu_A", lu.lu_A, 32'h1357_9BDF);
    check("stab_lu_B", lu.lu_B, 32'hFFFF_0000);
    n = 2;
    while (done0 !== 1'b1 && done1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stab_latency", n, 5);
    check("stab_done", {30'd0, done1, done0}, 1);
    check("stab_res0", res0, 32'hFFFF_9BDF);
    check("stab_res1_hold", res1, res_hold[1]);
    res_hold[0] = 32'hFFFF_9BDF;
    @(negedge clk);
    check("stab_done_width", {30'd0, done1, done0}, 0);

    // Reset in the middle of WAIT aborts with no done pulse.
    req1 = 1'b1;  a1 = 32'hCAFE_F00D;  b1 = 32'h0;  op1 = OP_OR;
    unit_lat = 4;
    n = 0;
    while (lu.lu_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_start", lu.lu_start, 1);
    @(negedge clk);
    rst  = 1'b1;
    req1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_no_done", {30'd0, done1, done0}, 0);
      check("abort_busy", busy, 0);
    end
    check("abort_res0", res0, 0);
    check("abort_res1", res1, 0);
    rst         = 1'b0;
    res_hold[0] = '0;
    res_hold[1] = '0;
    ptr_model   = 1'b0;
    @(negedge clk);
    check("abort_idle", busy, 0);

    // Randomized traffic: a requester stays pending until served.
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int t = 0; t < 200; t++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i] && ($urandom_range(0, 1) == 1 || (i == 1 && !pend[0]))) begin
          pend[i] = 1'b1;
          ra[i]   = $urandom();
          rb[i]   = $urandom();
          rop[i]  = OPW'($urandom_range(0, 7));
        end
      end
      win = (pend[0] && pend[1]) ? ptr_model : pend[1];
      v.r0 = pend[0];  v.a0 = ra[0];  v.b0 = rb[0];  v.op0 = rop[0];
      v.r1 = pend[1];  v.a1 = ra[1];  v.b1 = rb[1];  v.op1 = rop[1];
      v.lat       = $urandom_range(1, 6);
      v.exp_owner = win;
      v.exp_res   = lu_func(rop[win], ra[win], rb[win]);
      run_txn(v, 1, sw);
      pend[win] = 1'b0;
      ptr_model = !win;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);

`ifdef LOGIC_ARB_TIMEOUT_EN
    // Watchdog: finish never comes, done follows 16 WAIT cycles.
    unit_en = 1'b0;
    req0 = 1'b1;  a0 = 32'h1;  b0 = 32'h2;  op0 = OP_AND;
    n = 0;
    while (lu.lu_start !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wd_start", lu.lu_start, 1);
    n = 0;
    while (done0 !== 1'b1 && done1 !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("wd_latency", n, 17);
    check("wd_done", {30'd0, done1, done0}, 1);
    check("wd_err", err, 1);
    check("wd_res0", res0, 32'hFFFF_FFFF);
    req0 = 1'b0;
    @(negedge clk);
    check("wd_err_width", err, 0);
    check("wd_idle", busy, 0);
    unit_en = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/logic_op_arbiter.md
Name: logic_op_arbiter

Overview:
- Shares one Logic_op unit (A/B/log_op/start -> C/finish) between two requesters, e.g. the ALU issue path and a debug/self-test port.
- Round-robin arbitration; owns the unit's start/finish handshake.
- Latches operands on grant and returns the 32-bit result with a one-cycle done pulse to the winning requester.

Parameters:
- WIDTH, 32, operand/result width.
- OPW, 3, log_op width.
- TIMEOUT, 16, watchdog limit in WAIT cycles; used only with the optional feature.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 wants an operation; held high until done0.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- op0  input  OPW  requester 0 operation select.
- done0  output  1  one-cycle pulse: res0 valid.
- res0  output  WIDTH  requester 0 result; holds until its next done0.
- req1, a1, b1, op1, done1, res1: identical set for requester 1.
- lu_A  output  WIDTH  to Logic_op A.
- lu_B  output  WIDTH  to Logic_op B.
- lu_op  output  OPW  to Logic_op log_op.
- lu_start  output  1  to Logic_op start.
- lu_C  input  WIDTH  from Logic_op C.
- lu_finish  input  1  from Logic_op finish; treated as a level.
- busy  output  1  high in any state other than IDLE.
- owner  output  1  requester currently or last served.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, lu_start=0, lu_A/lu_B/lu_op=0, done0/done1=0, res0/res1=0, busy=0, owner=0, rr pointer=0 (requester 0 has priority).
- Reset mid-operation: abort immediately; no done pulse is issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> ISSUE when (req0|req1) and lu_finish==0.
  - Winner: the only requester, or the pointer's requester if both request.
  - On this edge: latch winner's a/b/op into lu_A/lu_B/lu_op and set owner.
  - While lu_finish==1 in IDLE (stale finish), no grant; stay in IDLE.
- ISSUE: lu_start=1 for exactly this one cycle. -> WAIT unconditionally.
- WAIT: lu_start=0; lu_A/lu_B/lu_op stay stable. On lu_finish==1: capture lu_C into res[owner], -> RESP.
- RESP: done[owner]=1 for exactly this one cycle; pointer = ~owner. -> IDLE.
- Latency: req seen in IDLE at cycle t -> lu_start at t+1 -> WAIT from t+2. If finish is first high at cycle f, done at f+1. Minimum request-to-done is 3 cycles.
- Back-to-back requests:
  - After RESP the arbiter returns to IDLE, so one idle cycle minimum between operations.
  - Fairness: with both reqs held high continuously, grants alternate 0,1,0,1.
- Requester drops req during ISSUE/WAIT: operation still completes; done still pulses. The requester must ignore an unwanted pulse.
- Operand changes after grant have no effect; latched values are used.
- done0 and done1 are never high in the same cycle. The non-owner's res holds its value.
- No arithmetic in this block; all data paths are WIDTH wide with no truncation.

Optional Feature:
- Macro: LOGIC_ARB_TIMEOUT_EN.
- Defined:
  - 5-bit-minimum watchdog counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches TIMEOUT with lu_finish still 0: go to RESP, write res[owner]=all-ones, and pulse done[owner] plus output err (1 bit, same cycle as done). err is 0 otherwise and at reset.
- Not defined: no counter, no err port; WAIT waits indefinitely for lu_finish.

Test Plan:
- Reset: assert rst 2 cycles while req0=1 -> all outputs 0, busy=0; first lu_start 2 cycles after rst falls (IDLE->ISSUE edge, start high next cycle).
- Single op: req0=1, a0=0xF0F0F0F0, b0=0x0FF00FF0, op0=AND; model finishes 1 cycle after start with C=0x00F000F0 -> done0 at t+3, res0=0x00F000F0, done1 never pulses.
- Contention: req0=req1=1 held; four operations -> owner sequence 0,1,0,1; each done pulse is exactly 1 cycle; res values match each requester's operands.
- Stale finish: lu_finish forced 1 in IDLE with req1=1 -> no lu_start until finish drops. Then normal issue.
- Operand stability: change a0 to 0 while in WAIT -> lu_A keeps the latched value; res0 matches the original operands. Drop req0 in WAIT -> done0 still pulses.
- With LOGIC_ARB_TIMEOUT_EN, TIMEOUT=16: finish never asserted -> after 16 WAIT cycles, done0=1, err=1, res0=0xFFFFFFFF, back to IDLE.
